// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by PC word
// bits, with a registered mispredict pulse and saturating branch/mispredict statistics.
module branch_predictor #(
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      pc_i,
    output logic             predict_taken_o,
    input  logic             upd_valid_i,
    input  logic [31:0]      upd_pc_i,
    input  logic             branch_result_i,
    input  logic             upd_predicted_i,
    output logic             mispredict_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    localparam int ENTRIES = 1 << IDX_W;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] ST  = 2'b11;

    logic [1:0]       tbl_q [ENTRIES];
    logic [1:0]       tbl_d [ENTRIES];
    logic             mispredict_q, mispredict_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] upd_idx;

    assign lookup_idx = pc_i[IDX_W+1:2];
    assign upd_idx    = upd_pc_i[IDX_W+1:2];

    // Reads the registered table, so a same-cycle update shows up one cycle later.
    assign predict_taken_o = tbl_q[lookup_idx][1];

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            tbl_d[i] = tbl_q[i];
            // Gating on upd_valid_i first keeps an X upd_pc_i from reaching the table.
            if (upd_valid_i && (upd_idx == i[IDX_W-1:0])) begin
                if (branch_result_i) begin
                    if (tbl_q[i] != ST) begin
                        tbl_d[i] = tbl_q[i] + 2'd1;
                    end
                end else begin
                    if (tbl_q[i] != SNT) begin
                        tbl_d[i] = tbl_q[i] - 2'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        mispredict_d  = upd_valid_i && (branch_result_i != upd_predicted_i);
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd_valid_i && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + 1'b1;
        end
        if (mispredict_d && (mispred_cnt_q != '1)) begin
            mispred_cnt_d = mispred_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i] <= WNT;
            end
            mispredict_q  <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i] <= tbl_d[i];
            end
            mispredict_q  <= mispredict_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign mispredict_o  = mispredict_q;
    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random updates
// compared against an integer-arithmetic model of the prediction table and statistics.
`timescale 1ns/100ps
module tb_branch_predictor;

    localparam int IDX_W = 4;
    localparam int CNT_W = 16;
    localparam int ENT   = 1 << IDX_W;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic [31:0]      pc_i = '0;
    logic             predict_taken_o;
    logic             upd_valid_i = 1'b0;
    logic [31:0]      upd_pc_i = '0;
    logic             branch_result_i = 1'b0;
    logic             upd_predicted_i = 1'b0;
    logic             mispredict_o;
    logic [CNT_W-1:0] branch_cnt_o;
    logic [CNT_W-1:0] mispred_cnt_o;

    int checks = 0;
    int errors = 0;

    // Model: each entry is a confidence level 0..3, predicting taken at 2 or above.
    int m_tbl [ENT];
    int m_bcnt;
    int m_mcnt;
    bit m_mis;

    branch_predictor #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .pc_i            (pc_i),
        .predict_taken_o (predict_taken_o),
        .upd_valid_i     (upd_valid_i),
        .upd_pc_i        (upd_pc_i),
        .branch_result_i (branch_result_i),
        .upd_predicted_i (upd_predicted_i),
        .mispredict_o    (mispredict_o),
        .branch_cnt_o    (branch_cnt_o),
        .mispred_cnt_o   (mispred_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENT);
    endfunction

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < ENT; i++) m_tbl[i] = 1;
            m_bcnt = 0;
            m_mcnt = 0;
            m_mis  = 1'b0;
        end else begin
            m_mis = 1'b0;
            if (upd_valid_i === 1'b1) begin
                int k;
                k = idx_of(upd_pc_i);
                if (branch_result_i) m_tbl[k] = (m_tbl[k] == 3) ? 3 : m_tbl[k] + 1;
                else                 m_tbl[k] = (m_tbl[k] == 0) ? 0 : m_tbl[k] - 1;
                if (m_bcnt < CMAX) m_bcnt = m_bcnt + 1;
                if (branch_result_i != upd_predicted_i) begin
                    m_mis = 1'b1;
                    if (m_mcnt < CMAX) m_mcnt = m_mcnt + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_pred(input logic [31:0] pc);
        return (m_tbl[idx_of(pc)] >= 2);
    endfunction

    // Called at posedge+1: drive, check the lookup before the edge, then the registered outputs.
    task automatic do_cycle(input logic v, input logic [31:0] upc, input logic res,
                            input logic pred, input logic [31:0] pc);
        upd_valid_i     = v;
        upd_pc_i        = upc;
        branch_result_i = res;
        upd_predicted_i = pred;
        pc_i            = pc;
        #1;
        chk("predict_pre_edge", {31'd0, predict_taken_o}, {31'd0, model_pred(pc)});
        @(posedge clk_i);
        #1;
        chk("mispredict", {31'd0, mispredict_o}, {31'd0, m_mis});
        chk("branch_cnt", {16'd0, branch_cnt_o}, m_bcnt);
        chk("mispred_cnt", {16'd0, mispred_cnt_o}, m_mcnt);
        $display("cycle v=%0b upd_pc=%h res=%0b pred=%0b pc=%h -> taken=%0b mis=%0b bcnt=%0d mcnt=%0d",
                 v, upc, res, pred, pc, predict_taken_o, mispredict_o, branch_cnt_o, mispred_cnt_o);
    endtask

    task automatic probe(input logic [31:0] pc, input logic exp, input string tag);
        pc_i = pc;
        #0.1;
        chk(tag, {31'd0, predict_taken_o}, {31'd0, exp});
    endtask

    initial begin
        // Reset state: every lookup predicts not-taken, statistics clear.
        #2;
        for (int a = 0; a <= 'h3C; a += 4) probe(a, 1'b0, "reset_predict");
        chk("reset_bcnt", {16'd0, branch_cnt_o}, 0);
        chk("reset_mcnt", {16'd0, mispred_cnt_o}, 0);
        chk("reset_mis", {31'd0, mispredict_o}, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Same-cycle lookup and update of index 3.
        do_cycle(1'b1, 32'hC, 1'b1, 1'b0, 32'hC);
        chk("same_cycle_next", {31'd0, predict_taken_o}, 1);

        // Aliasing: 0x4 and 0x44 share index 1.
        do_cycle(1'b1, 32'h4, 1'b1, 1'b0, 32'h44);
        do_cycle(1'b1, 32'h4, 1'b1, 1'b1, 32'h44);
        probe(32'h44, 1'b1, "alias_44");
        probe(32'h8, 1'b0, "alias_8");

        // Two mispredicted taken updates at 0x8.
        begin
            int b0, m0;
            b0 = m_bcnt; m0 = m_mcnt;
            do_cycle(1'b1, 32'h8, 1'b1, 1'b0, 32'h8);
            chk("pulse1", {31'd0, mispredict_o}, 1);
            do_cycle(1'b1, 32'h8, 1'b1, 1'b0, 32'h8);
            chk("pulse2", {31'd0, mispredict_o}, 1);
            chk("pc8_taken", {31'd0, predict_taken_o}, 1);
            chk("two_mcnt", {16'd0, mispred_cnt_o}, m0 + 2);
            chk("two_bcnt", {16'd0, branch_cnt_o}, b0 + 2);
        end

        // Walk index 2 down from strongly taken.
        do_cycle(1'b1, 32'h8, 1'b1, 1'b1, 32'h8);
        do_cycle(1'b1, 32'h8, 1'b0, 1'b1, 32'h8);
        probe(32'h8, 1'b1, "st_to_wt");
        do_cycle(1'b1, 32'h8, 1'b0, 1'b1, 32'h8);
        probe(32'h8, 1'b0, "wt_to_wnt");
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 32'h8, 1'b0, 1'b0, 32'h8);
        do_cycle(1'b1, 32'h8, 1'b1, 1'b0, 32'h8);
        probe(32'h8, 1'b0, "snt_hold");

        // Unknown update fields while idle must not disturb outputs.
        do_cycle(1'b0, 32'hx, 1'bx, 1'bx, 32'h8);
        chk("idle_x_mis", {31'd0, mispredict_o}, 0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            do_cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), $urandom);
        end

        // Reset mid-stream with a pulse outstanding and an update presented.
        do_cycle(1'b1, 32'h10, 1'b1, 1'b0, 32'h10);
        chk("pre_reset_mis", {31'd0, mispredict_o}, 1);
        upd_valid_i = 1'b1; branch_result_i = 1'b1; upd_predicted_i = 1'b0;
        #1;
        rst_i = 1'b0;
        #0.2;
        chk("async_mis", {31'd0, mispredict_o}, 0);
        chk("async_bcnt", {16'd0, branch_cnt_o}, 0);
        chk("async_mcnt", {16'd0, mispred_cnt_o}, 0);
        for (int a = 0; a < ENT; a++) probe(a * 4, 1'b0, "async_table");
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        upd_valid_i = 1'b0;
        do_cycle(1'b1, 32'h10, 1'b1, 1'b1, 32'h10);
        chk("first_update_bcnt", {16'd0, branch_cnt_o}, 1);

        // Saturation of the branch counter.
        for (int n = 0; n < (1 << CNT_W) + 3; n++) begin
            logic r;
            r = 1'($urandom_range(0, 1));
            do_cycle(1'b1, $urandom, r, r, $urandom);
        end
        chk("bcnt_saturated", {16'd0, branch_cnt_o}, 32'h0000FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
